// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, FSM state encoding and parity helper for the
// PS/2 scan-code receiver (ps2_edge_filter, ps2_scan_receiver).
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } ps2_state_t;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic ps2_odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// ps2_edge_filter: conditions the asynchronous PS/2 clock.
//   2-flop synchroniser, then a level filter that only changes its output after
//   FILTER_LEN consecutive samples disagree with it, then a one-cycle strobe on
//   each filtered 1->0 transition.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-high reset (filtered level returns to idle-high)
//   i_ps2c  in  raw PS/2 clock, asynchronous
//   o_fall  out one-cycle strobe on each filtered falling edge
module ps2_edge_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2c,
  output logic o_fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_filt;
  logic [CW-1:0] r_cnt;
  logic          r_fall;

  always_ff @(posedge clk) begin
    r_s1 <= i_ps2c;
    r_s2 <= r_s1;
  end

  // Count samples that disagree with the filtered level; any agreeing sample
  // restarts the count, so only a stable new level gets through.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt <= 1'b1;
      r_cnt  <= '0;
      r_fall <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_s2 != r_filt) begin
        if (r_cnt == CNT_LAST) begin
          r_filt <= r_s2;
          r_cnt  <= '0;
          r_fall <= ~r_s2;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_fall = r_fall;

endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: receives PS/2 keyboard frames and emits one make code per
// key press. Break sequences (F0 xx) and extended prefixes (E0) are absorbed.
// Optional build macro: PS2_PARITY_CHK_EN -- when defined, frames with bad odd
// parity are rejected with frame_err; otherwise the parity bit is ignored.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   ps2c       in   PS/2 clock, asynchronous
//   ps2d       in   PS/2 data, asynchronous
//   rx_en      in   receive enable, only looked at while idle
//   scan_code  out  last accepted make code, held until the next one
//   code_tick  out  one-cycle pulse when scan_code is updated
//   frame_err  out  one-cycle pulse on a bad frame or watchdog timeout
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] scan_code,
  output logic       code_tick,
  output logic       frame_err
);

  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]     CNT_LAST = 4'(PS2_FRAME_BITS - 1);

  ps2_state_t      r_state;
  ps2_state_t      w_state_next;
  logic            r_d1;
  logic            r_d2;
  logic [10:0]     r_shift;
  logic [3:0]      r_cnt;
  logic [WDW-1:0]  r_wd;
  logic            r_break_pend;
  logic [7:0]      r_scan_code;
  logic            r_tick;
  logic            r_err;

  logic            w_fall;
  logic [7:0]      w_byte;
  logic            w_frame_ok;
  logic            w_tick_next;
  logic            w_err_next;
  logic            w_load;
  logic            w_bp_next;

  ps2_edge_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filt (
    .clk    (clk),
    .reset  (reset),
    .i_ps2c (ps2c),
    .o_fall (w_fall)
  );

  // ps2d only needs metastability protection: it is stable around the
  // keyboard's falling clock edge, and the ps2c path is the slower one.
  always_ff @(posedge clk) begin
    r_d1 <= ps2d;
    r_d2 <= r_d1;
  end

  // Frame is shifted in LSB first from the top, so after 11 bits:
  // [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign w_byte = r_shift[8:1];

`ifdef PS2_PARITY_CHK_EN
  assign w_frame_ok = ~r_shift[0] & r_shift[10] & ps2_odd_parity_ok(r_shift[8:1], r_shift[9]);
`else
  assign w_frame_ok = ~r_shift[0] & r_shift[10];
`endif

  always_comb begin
    w_state_next = r_state;
    w_tick_next  = 1'b0;
    w_err_next   = 1'b0;
    w_load       = 1'b0;
    w_bp_next    = r_break_pend;
    unique case (r_state)
      IDLE: begin
        if (rx_en && w_fall && !r_d2) w_state_next = SHIFT;
      end
      SHIFT: begin
        // A fall in the timeout cycle keeps the frame alive.
        if (w_fall) begin
          if (r_cnt == CNT_LAST) w_state_next = CHECK;
        end else if (r_wd == WD_LAST) begin
          w_state_next = IDLE;
          w_err_next   = 1'b1;
        end
      end
      CHECK: begin
        w_state_next = IDLE;
        if (!w_frame_ok) begin
          w_err_next = 1'b1;
          w_bp_next  = 1'b0;
        end else if (w_byte == PS2_BREAK) begin
          w_bp_next = 1'b1;
        end else if (w_byte == PS2_EXT) begin
          w_bp_next = r_break_pend;
        end else if (r_break_pend) begin
          w_bp_next = 1'b0;
        end else begin
          w_load      = 1'b1;
          w_tick_next = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // r_wd counts cycles since the last fall (1 in the cycle after it), so the
  // registered frame_err lands exactly TIMEOUT_CYC cycles after that fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_wd         <= '0;
      r_break_pend <= 1'b0;
      r_scan_code  <= 8'h00;
      r_tick       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_tick       <= w_tick_next;
      r_err        <= w_err_next;
      r_break_pend <= w_bp_next;
      if (w_load) r_scan_code <= w_byte;
      case (r_state)
        IDLE: begin
          if (w_state_next == SHIFT) begin
            r_shift <= {r_d2, r_shift[10:1]};
            r_cnt   <= 4'd1;
            r_wd    <= WDW'(1);
          end
        end
        SHIFT: begin
          if (w_fall) begin
            r_shift <= {r_d2, r_shift[10:1]};
            r_cnt   <= r_cnt + 4'd1;
            r_wd    <= WDW'(1);
          end else begin
            r_wd <= r_wd + WDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign scan_code = r_scan_code;
  assign code_tick = r_tick;
  assign frame_err = r_err;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
module tb_ps2_scan_receiver;

  localparam int FL = 8;
  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic [7:0] scan_code;
  logic       code_tick;
  logic       frame_err;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int n_tick = 0;
  int n_err = 0;
  int last_tick_cyc = 0;
  int last_err_cyc = 0;
  logic [7:0] last_code = 8'h00;
  int drop_cyc = 0;

  ps2_scan_receiver #(
    .FILTER_LEN  (FL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .rx_en     (rx_en),
    .scan_code (scan_code),
    .code_tick (code_tick),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (code_tick) begin
      n_tick        <= n_tick + 1;
      last_code     <= scan_code;
      last_tick_cyc <= cyc;
    end
    if (frame_err) begin
      n_err        <= n_err + 1;
      last_err_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // {stop, parity, data, start}; parity is odd unless bad_par is set.
  function automatic logic [10:0] mk(input logic [7:0] b, input logic stop, input logic bad_par);
    logic p;
    p = (~^b) ^ bad_par;
    return {stop, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ps2d = v[i];
      idle(10);
      ps2c = 1'b0;
      drop_cyc = cyc;
      idle(20);
      ps2c = 1'b1;
      idle(20);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk(b, 1'b1, 1'b0), 0, 10);
  endtask

  int t0;
  int e0;

  initial begin
    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    rx_en = 1'b1;
    idle(5);
    check("rst_scan_code", 32'(scan_code), 32'h00);
    check("rst_code_tick", 32'(code_tick), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    idle(30);

    // 1: single make code 1C, with latency from the 11th ps2c drop
    t0 = n_tick; e0 = n_err;
    send_byte(8'h1C);
    idle(5);
    check("t1_ticks", 32'(n_tick - t0), 32'd1);
    check("t1_code", 32'(last_code), 32'h1C);
    check("t1_scan_hold", 32'(scan_code), 32'h1C);
    check("t1_errs", 32'(n_err - e0), 32'd0);
    check("t1_latency", 32'(last_tick_cyc - drop_cyc), 32'd12);

    // 2: 1C F0 1C -> one tick; a following 1C ticks again (break cleared)
    t0 = n_tick; e0 = n_err;
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    idle(5);
    check("t2_ticks", 32'(n_tick - t0), 32'd1);
    check("t2_code", 32'(last_code), 32'h1C);
    check("t2_errs", 32'(n_err - e0), 32'd0);
    t0 = n_tick;
    send_byte(8'h1C);
    idle(5);
    check("t2_break_cleared", 32'(n_tick - t0), 32'd1);

    // 3: E0 5A -> single tick 5A
    t0 = n_tick;
    send_byte(8'hE0);
    send_byte(8'h5A);
    idle(5);
    check("t3_ticks", 32'(n_tick - t0), 32'd1);
    check("t3_code", 32'(last_code), 32'h5A);

    // 4: 2C with stop=0 -> frame_err, no tick, scan_code held at 5A
    t0 = n_tick; e0 = n_err;
    send_bits(mk(8'h2C, 1'b0, 1'b0), 0, 10);
    idle(5);
    check("t4_errs", 32'(n_err - e0), 32'd1);
    check("t4_ticks", 32'(n_tick - t0), 32'd0);
    check("t4_scan_hold", 32'(scan_code), 32'h5A);

    // 5: 2C with even parity
    t0 = n_tick; e0 = n_err;
    send_bits(mk(8'h2C, 1'b1, 1'b1), 0, 10);
    idle(5);
`ifdef PS2_PARITY_CHK_EN
    check("t5_errs", 32'(n_err - e0), 32'd1);
    check("t5_ticks", 32'(n_tick - t0), 32'd0);
    check("t5_scan", 32'(scan_code), 32'h5A);
`else
    check("t5_errs", 32'(n_err - e0), 32'd0);
    check("t5_ticks", 32'(n_tick - t0), 32'd1);
    check("t5_scan", 32'(scan_code), 32'h2C);
`endif

    // 6: 5 bits then silence -> timeout; 3A afterwards ticks
    t0 = n_tick; e0 = n_err;
    send_bits(mk(8'h3A, 1'b1, 1'b0), 0, 4);
    idle(TO + 50);
    check("t6_errs", 32'(n_err - e0), 32'd1);
    check("t6_err_time", 32'(last_err_cyc - drop_cyc), 32'(10 + TO));
    check("t6_ticks", 32'(n_tick - t0), 32'd0);
    t0 = n_tick;
    send_byte(8'h3A);
    idle(5);
    check("t6_after_ticks", 32'(n_tick - t0), 32'd1);
    check("t6_after_code", 32'(last_code), 32'h3A);

    // rx_en low while idle: frame ignored
    t0 = n_tick; e0 = n_err;
    rx_en = 1'b0;
    send_byte(8'h1C);
    idle(5);
    check("rxen_off_ticks", 32'(n_tick - t0), 32'd0);
    check("rxen_off_errs", 32'(n_err - e0), 32'd0);

    // rx_en dropped mid-frame: frame still completes
    rx_en = 1'b1;
    t0 = n_tick;
    send_bits(mk(8'h6B, 1'b1, 1'b0), 0, 2);
    rx_en = 1'b0;
    send_bits(mk(8'h6B, 1'b1, 1'b0), 3, 10);
    idle(5);
    check("rxen_mid_ticks", 32'(n_tick - t0), 32'd1);
    check("rxen_mid_code", 32'(last_code), 32'h6B);
    rx_en = 1'b1;

    // Reset mid-frame: outputs return to reset values, no pulses, then 15 ticks
    t0 = n_tick; e0 = n_err;
    send_bits(mk(8'h15, 1'b1, 1'b0), 0, 3);
    reset = 1'b1;
    idle(2);
    check("mid_rst_scan", 32'(scan_code), 32'h00);
    check("mid_rst_tick", 32'(code_tick), 32'h0);
    check("mid_rst_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    idle(TO + 50);
    check("mid_rst_no_err", 32'(n_err - e0), 32'd0);
    check("mid_rst_no_tick", 32'(n_tick - t0), 32'd0);
    send_byte(8'h15);
    idle(5);
    check("post_rst_ticks", 32'(n_tick - t0), 32'd1);
    check("post_rst_code", 32'(scan_code), 32'h15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
